matmul_stream_adapter: RTL
==========================

Name: matmul_stream_adapter

Overview:
- Streaming front/back end for matrix_multiplication.
- Collects A then B as a row-major stream of 32-bit Q20.12 elements and packs them into the 1152-bit Ain/Bin buses.
- Drives the start/done handshake, captures Cout and streams C back out row-major.
- Sits between the system datapath (e.g. filter update logic) and the multiplier, so no upstream block handles packed buses.

Parameters:
- DATA_W, 32, element width (Q20.12); fixed, must match multiplier.
- MAX_DIM, 6, maximum rows/cols of any operand.
- BUS_W, 1152, packed bus width = MAX_DIM*MAX_DIM*DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_valid  in  1  dimension set offered
- cfg_ready  out  1  adapter accepts cfg (high only in IDLE)
- cfg_rows_a / cfg_cols_a / cfg_cols_b  in  8 each  dimensions
- cfg_err  out  1  one-cycle pulse: cfg rejected
- in_valid  in  1  element offered
- in_ready  out  1  element accepted (LOAD_A/LOAD_B only)
- in_data  in  32  element, A then B, row-major
- out_valid  out  1  C element valid
- out_ready  in  1  downstream accepts
- out_data  out  32  C element, row-major
- out_last  out  1  high with final C element
- busy  out  1  high in any state but IDLE
- mm_start  out  1  to multiplier start
- mm_rows_a / mm_cols_a / mm_cols_b  out  8 each  latched dims to multiplier
- mm_ain / mm_bin  out  1152 each  packed A/B, element n at bits [32n+31:32n]
- mm_cout  in  1152  packed C from multiplier
- mm_done  in  1  multiplier done

Behaviour:
- Reset (rst_n low at posedge): state IDLE; every output 0 (cfg_ready 0 that cycle, mm_ain/mm_bin cleared, counters 0). Reset mid-operation abandons the job and drops mm_start; the multiplier shares the same system reset.
- IDLE: cfg_ready=1.
  - On cfg_valid, check each dim in 1..MAX_DIM.
  - Illegal: cfg_err pulses 1 cycle; stay IDLE; nothing latched.
  - Legal: latch dims; clear mm_ain/mm_bin to 0; nA=rows*colsA, nB=colsA*colsB, nC=rows*colsB; count=0; go LOAD_A.
- LOAD_A: in_ready=1. Each in_valid&in_ready writes in_data to mm_ain slot[count] (compact stride colsA, as the multiplier indexes). After element nA-1: count=0, go LOAD_B.
- LOAD_B: same as LOAD_A into mm_bin, nB elements. After the last one, go RUN with mm_start=1 on the following cycle.
- RUN: hold mm_start=1 until mm_done=1 is sampled. Mm_cout is valid in that same cycle. On that edge: capture mm_cout into local c_buf, drop mm_start to 0, count=0, go DRAIN.
- DRAIN: out_valid=1; out_data=c_buf slot[count]; out_last=(count==nC-1).
  - out_data is held stable while out_valid&&!out_ready.
  - On handshake, count++.
  - After the last element, go RELEASE.
- RELEASE: wait for mm_done=0 (the multiplier has returned to IDLE), then go IDLE. This guarantees mm_start never re-rises while the multiplier is in DONE.
- Unused slots (index >= n) remain 0 in all buses. Extra in_valid data outside the LOAD states is not accepted (in_ready=0).
- Minimum latency, with in_valid and out_ready held high: cfg accept -> first out_valid = nA+nB+1 cycles plus multiplier time (~(colsA+1)*nC+3).
- Arithmetic: none. Elements are passed bit-exact; no saturation or reformatting.

Decomposition:
- Shared package mm_pkg: DATA_W, MAX_DIM, BUS_W, FRAC_BITS=12, and the state encoding (IDLE, LOAD_A, LOAD_B, RUN, DRAIN, RELEASE).
- Sub-module: mm_slot_writer, a generic one-slot write into a packed bus at an index, instantiated twice (A and B). The output mux over c_buf stays inline.

Test Plan:
- 2x2 identity: cfg (2,2,2); A=[4096,0,0,4096]; B=[8192,4096,-4096,12288] -> out = B values in order; out_last on 4th; mm_ain slots 4..35 = 0.
- Non-square: cfg (2,3,1); A=[4096,8192,12288,4096,4096,4096]; B=[4096,4096,4096] -> out = [24576,12288], 2 elements, last on 2nd.
- Illegal cfg: (0,3,3), then (7,1,1) -> cfg_err pulses each, busy stays 0, in_ready 0; next legal cfg accepted.
- Backpressure: 6x6 job with out_ready toggling 1-0-0-1 -> all 36 elements delivered once, in order, stable while stalled.
- Input gaps: in_valid low on alternate cycles during load -> same result as gap-free; mm_start only after the 2nd operand's last element.
- Reset during RUN: rst_n low 1 cycle -> next cycle all outputs 0, IDLE; new job then completes correctly; mm_start never asserted while mm_done=1.

Source files
------------

// File: rtl/matmul_stream_adapter_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared constants and state encoding for the matrix-multiplier stream adapter.
//   DATA_W    : element width (Q20.12), must match the multiplier
//   MAX_DIM   : largest row/column count of any operand
//   SLOTS     : element slots in one packed bus
//   BUS_W     : packed bus width (SLOTS * DATA_W)
//   FRAC_BITS : fractional bits of the element format
//   DIM_W     : width of a dimension field
//   CNT_W     : width of an element counter (holds 0..SLOTS)
// -----------------------------------------------------------------------------
package mm_pkg;

  localparam int DATA_W    = 32;
  localparam int MAX_DIM   = 6;
  localparam int SLOTS     = MAX_DIM * MAX_DIM;
  localparam int BUS_W     = SLOTS * DATA_W;
  localparam int FRAC_BITS = 12;
  localparam int DIM_W     = 8;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4,
    RELEASE = 3'd5
  } state_e;

  // A dimension is usable when it lies in 1..MAX_DIM.
  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction

  // Element count of an a x b operand. Only meaningful for legal dims, where
  // the product is at most SLOTS and fits a counter.
  function automatic logic [CNT_W-1:0] slot_count(input logic [DIM_W-1:0] a,
                                                  input logic [DIM_W-1:0] b);
    logic [CNT_W-1:0] a_n;
    logic [CNT_W-1:0] b_n;
    a_n = a[CNT_W-1:0];
    b_n = b[CNT_W-1:0];
    return a_n * b_n;
  endfunction

endpackage

// File: rtl/matmul_stream_adapter_if.sv
// -----------------------------------------------------------------------------
// matmul_stream_adapter_if
// Bundles every signal of the adapter except clock and reset.
//   cfg_*   : dimension offer / accept / reject
//   in_*    : element stream in (A then B, row-major)
//   out_*   : result stream out (C, row-major)
//   busy    : adapter is not idle
//   mm_*    : packed-bus side toward the matrix multiplier
// Modports:
//   master : the adapter itself
//   slave  : the environment (upstream/downstream logic plus multiplier)
// -----------------------------------------------------------------------------
interface matmul_stream_adapter_if;
  import mm_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIM_W-1:0] cfg_rows_a;
  logic [DIM_W-1:0] cfg_cols_a;
  logic [DIM_W-1:0] cfg_cols_b;
  logic             cfg_err;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic busy;

  logic             mm_start;
  logic [DIM_W-1:0] mm_rows_a;
  logic [DIM_W-1:0] mm_cols_a;
  logic [DIM_W-1:0] mm_cols_b;
  logic [BUS_W-1:0] mm_ain;
  logic [BUS_W-1:0] mm_bin;
  logic [BUS_W-1:0] mm_cout;
  logic             mm_done;

  modport master (
    input  cfg_valid, cfg_rows_a, cfg_cols_a, cfg_cols_b,
    output cfg_ready, cfg_err,
    input  in_valid, in_data,
    output in_ready,
    input  out_ready,
    output out_valid, out_data, out_last,
    output busy,
    output mm_start, mm_rows_a, mm_cols_a, mm_cols_b, mm_ain, mm_bin,
    input  mm_cout, mm_done
  );

  modport slave (
    output cfg_valid, cfg_rows_a, cfg_cols_a, cfg_cols_b,
    input  cfg_ready, cfg_err,
    output in_valid, in_data,
    input  in_ready,
    output out_ready,
    input  out_valid, out_data, out_last,
    input  busy,
    input  mm_start, mm_rows_a, mm_cols_a, mm_cols_b, mm_ain, mm_bin,
    output mm_cout, mm_done
  );

endinterface

// File: rtl/matmul_stream_adapter_slot_writer.sv
// -----------------------------------------------------------------------------
// mm_slot_writer
// Combinational next-value for a packed bus register: optionally clears the
// whole bus, otherwise optionally replaces one DATA_W slot at index idx.
//   bus_i : current bus value
//   idx   : slot to write
//   data  : new slot contents
//   we    : write enable for slot idx
//   clr   : clear the whole bus (wins over we)
//   bus_o : next bus value
// -----------------------------------------------------------------------------
module mm_slot_writer #(
  parameter int DATA_W = 32,
  parameter int SLOTS  = 36,
  parameter int IDX_W  = 6
) (
  input  logic [SLOTS*DATA_W-1:0] bus_i,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_W-1:0]       data,
  input  logic                    we,
  input  logic                    clr,
  output logic [SLOTS*DATA_W-1:0] bus_o
);

  always_comb begin
    bus_o = clr ? '0 : bus_i;
    // Decoded per slot so an index beyond SLOTS simply writes nothing.
    for (int s = 0; s < SLOTS; s++) begin
      if (we && !clr && (idx == IDX_W'(s))) begin
        bus_o[s*DATA_W +: DATA_W] = data;
      end
    end
  end

endmodule

// File: rtl/matmul_stream_adapter.sv
// -----------------------------------------------------------------------------
// matmul_stream_adapter
// Streaming front/back end for the matrix multiplier. Accepts a dimension set,
// packs A then B from a row-major element stream into the multiplier's packed
// buses, runs the start/done handshake, captures C and streams it back out.
// Elements are passed bit-exact.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   io    : matmul_stream_adapter_if.master (cfg, in, out, busy, mm_* buses)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | cfg_ready high, waiting for a dimension set
//   LOAD_A  | accepting nA elements of A into mm_ain
//   LOAD_B  | accepting nB elements of B into mm_bin
//   RUN     | mm_start held high until mm_done, then C captured
//   DRAIN   | streaming nC elements of C out
//   RELEASE | waiting for mm_done to fall before going idle
// -----------------------------------------------------------------------------
module matmul_stream_adapter
  import mm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  matmul_stream_adapter_if.master io
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DIM_W-1:0] rows_q, rows_d;
  logic [DIM_W-1:0] cols_a_q, cols_a_d;
  logic [DIM_W-1:0] cols_b_q, cols_b_d;
  logic [CNT_W-1:0] n_a_q, n_a_d;
  logic [CNT_W-1:0] n_b_q, n_b_d;
  logic [CNT_W-1:0] n_c_q, n_c_d;
  logic [BUS_W-1:0] ain_q, ain_d;
  logic [BUS_W-1:0] bin_q, bin_d;
  logic [BUS_W-1:0] cbuf_q, cbuf_d;
  logic             cfg_err_q, cfg_err_d;
  logic             armed_q, armed_d;

  logic              cfg_ready;
  logic              cfg_legal;
  logic              in_ready;
  logic              in_fire;
  logic              out_valid;
  logic              out_fire;
  logic              out_last;
  logic [DATA_W-1:0] out_word;
  logic              clr_ab;
  logic              we_a;
  logic              we_b;

  mm_slot_writer #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS),
    .IDX_W  (CNT_W)
  ) u_wr_a (
    .bus_i (ain_q),
    .idx   (count_q),
    .data  (io.in_data),
    .we    (we_a),
    .clr   (clr_ab),
    .bus_o (ain_d)
  );

  mm_slot_writer #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS),
    .IDX_W  (CNT_W)
  ) u_wr_b (
    .bus_i (bin_q),
    .idx   (count_q),
    .data  (io.in_data),
    .we    (we_b),
    .clr   (clr_ab),
    .bus_o (bin_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rows_q    <= '0;
      cols_a_q  <= '0;
      cols_b_q  <= '0;
      n_a_q     <= '0;
      n_b_q     <= '0;
      n_c_q     <= '0;
      ain_q     <= '0;
      bin_q     <= '0;
      cbuf_q    <= '0;
      cfg_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rows_q    <= rows_d;
      cols_a_q  <= cols_a_d;
      cols_b_q  <= cols_b_d;
      n_a_q     <= n_a_d;
      n_b_q     <= n_b_d;
      n_c_q     <= n_c_d;
      ain_q     <= ain_d;
      bin_q     <= bin_d;
      cbuf_q    <= cbuf_d;
      cfg_err_q <= cfg_err_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rows_d    = rows_q;
    cols_a_d  = cols_a_q;
    cols_b_d  = cols_b_q;
    n_a_d     = n_a_q;
    n_b_d     = n_b_q;
    n_c_d     = n_c_q;
    cbuf_d    = cbuf_q;
    cfg_err_d = 1'b0;
    armed_d   = 1'b1;
    clr_ab    = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;

    // armed_q keeps cfg_ready low for the first cycle out of reset so that
    // every output reads zero right after a reset edge.
    cfg_ready = (state_q == IDLE) && armed_q;
    cfg_legal = dim_ok(io.cfg_rows_a) && dim_ok(io.cfg_cols_a) && dim_ok(io.cfg_cols_b);
    in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    in_fire   = io.in_valid && in_ready;
    out_valid = (state_q == DRAIN);
    out_fire  = out_valid && io.out_ready;
    out_last  = out_valid && (count_q == n_c_q - CNT_W'(1));

    unique case (state_q)
      IDLE: begin
        if (io.cfg_valid && cfg_ready) begin
          if (cfg_legal) begin
            rows_d   = io.cfg_rows_a;
            cols_a_d = io.cfg_cols_a;
            cols_b_d = io.cfg_cols_b;
            n_a_d    = slot_count(io.cfg_rows_a, io.cfg_cols_a);
            n_b_d    = slot_count(io.cfg_cols_a, io.cfg_cols_b);
            n_c_d    = slot_count(io.cfg_rows_a, io.cfg_cols_b);
            count_d  = '0;
            clr_ab   = 1'b1;
            state_d  = LOAD_A;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      // Row-major with stride cols equals the compact slot index, so the
      // running element count is the slot number directly.
      LOAD_A: begin
        if (in_fire) begin
          we_a = 1'b1;
          if (count_q == n_a_q - CNT_W'(1)) begin
            count_d = '0;
            state_d = LOAD_B;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      LOAD_B: begin
        if (in_fire) begin
          we_b = 1'b1;
          if (count_q == n_b_q - CNT_W'(1)) begin
            count_d = '0;
            state_d = RUN;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      // mm_cout is valid in the same cycle mm_done is seen.
      RUN: begin
        if (io.mm_done) begin
          cbuf_d  = io.mm_cout;
          count_d = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (out_fire) begin
          if (out_last) begin
            count_d = '0;
            state_d = RELEASE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      // Holding here until mm_done falls keeps mm_start from re-rising while
      // the multiplier is still presenting its result.
      RELEASE: begin
        if (!io.mm_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_word = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (out_valid && (count_q == CNT_W'(s))) begin
        out_word = cbuf_q[s*DATA_W +: DATA_W];
      end
    end
  end

  assign io.cfg_ready = cfg_ready;
  assign io.cfg_err   = cfg_err_q;
  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_data  = out_word;
  assign io.out_last  = out_last;
  assign io.busy      = (state_q != IDLE);
  assign io.mm_start  = (state_q == RUN);
  assign io.mm_rows_a = rows_q;
  assign io.mm_cols_a = cols_a_q;
  assign io.mm_cols_b = cols_b_q;
  assign io.mm_ain    = ain_q;
  assign io.mm_bin    = bin_q;

endmodule
